// File: rtl/status_flag_unit.sv
// NZCV status register with in-flight flag-setter tracking and condition stall.
// Optional macro FLAG_FWD_EN adds a same-cycle EXE->ID flag bypass.
module status_flag_unit #(
   parameter  int unsigned MAX_PENDING = 3,
   localparam int unsigned CW          = $clog2(MAX_PENDING + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid,
   input  logic [3:0]    id_cond,
   input  logic          id_s,
   input  logic          freeze,
   input  logic          exe_valid,
   input  logic          exe_s,
   input  logic [3:0]    exe_flags,
   input  logic          flush,
   output logic [3:0]    flags,
   output logic [3:0]    cond_flags,
   output logic          cond_stall,
   output logic [CW-1:0] pending
);

   localparam logic [3:0]    COND_AL = 4'b1110;
   localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PENDING);

   logic exe_wr;
   logic id_cnd;
   logic id_issue;
   logic inc;
   logic dec;
   logic hazard;
   logic sat;

   always_comb begin
      exe_wr = exe_valid & exe_s;
      id_cnd = id_valid & (id_cond != COND_AL);
      dec    = exe_wr & (pending != '0);
`ifdef FLAG_FWD_EN
      // The sole pending setter committing now is bypassed, so it is no hazard.
      hazard     = (pending - CW'(dec)) != '0;
      cond_flags = exe_wr ? exe_flags : flags;
`else
      hazard     = pending != '0;
      cond_flags = flags;
`endif
      // A full tracker blocks every new setter so the count never wraps.
      sat        = id_valid & id_s & (pending == PEND_MAX);
      cond_stall = (id_cnd & hazard) | sat;
      id_issue   = id_valid & ~freeze & ~cond_stall & ~flush;
      inc        = id_issue & id_s;
   end

   // EXE commits flags even under flush: it is older than the branch target.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags   <= 4'b0000;
         pending <= '0;
      end else begin
         if (exe_wr) flags <= exe_flags;
         if (flush)  pending <= '0;
         else        pending <= pending + CW'(inc) - CW'(dec);
      end
   end

endmodule
